// File: rtl/sum_accumulator_pkg.sv
// Shared types and helpers for the frame sum accumulator.
package sum_accumulator_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  // Floor log2; used on power-of-two frame lengths so it is exact there.
  function automatic int log2_f(input int n);
    int r;
    r = 0;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) <= n) r = i;
    end
    return r;
  endfunction

endpackage

// File: rtl/sum_accumulator.sv
// Accumulates FRAME_LEN adder sums per frame and presents total, mean and
// overflow on an output valid/ready handshake.
module sum_accumulator
  import sum_accumulator_pkg::*;
#(
  parameter int IN_W      = 5,
  parameter int ACC_W     = 12,
  parameter int FRAME_LEN = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in_data,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [ACC_W-1:0] out_mean,
  output logic             out_ovf
);

  localparam int SHIFT = log2_f(FRAME_LEN);
  localparam int CNT_W = SHIFT + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_LEN - 1);

  state_t           state, state_nxt;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             ovf;
  logic [ACC_W:0]   acc_sum;
  logic             accept;
  logic             frame_done;

  function automatic logic [ACC_W-1:0] mean_of(input logic [ACC_W-1:0] s);
    return s >> SHIFT;
  endfunction

  // Extra top bit of acc_sum is the carry out of the accumulator.
  assign acc_sum    = {1'b0, acc} + {1'b0, ACC_W'(in_data)};
  assign accept     = in_valid && in_ready;
  assign frame_done = accept && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= ACCUM;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = ACCUM;
    end else begin
      case (state)
        ACCUM: if (frame_done) state_nxt = HOLD;
        HOLD:  if (out_ready)  state_nxt = ACCUM;
      endcase
    end
  end

  always_comb begin
    in_ready  = (state == ACCUM);
    out_valid = (state == HOLD);
  end

  // Accumulator is zeroed as the frame closes, so HOLD always re-enters ACCUM clean.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      cnt      <= '0;
      ovf      <= 1'b0;
      out_sum  <= '0;
      out_mean <= '0;
      out_ovf  <= 1'b0;
    end else if (clear) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (frame_done) begin
      acc      <= '0;
      cnt      <= '0;
      ovf      <= 1'b0;
      out_sum  <= acc_sum[ACC_W-1:0];
      out_mean <= mean_of(acc_sum[ACC_W-1:0]);
      out_ovf  <= ovf | acc_sum[ACC_W];
    end else if (accept) begin
      acc <= acc_sum[ACC_W-1:0];
      cnt <= cnt + CNT_W'(1);
      ovf <= ovf | acc_sum[ACC_W];
    end
  end

endmodule

// File: tb/tb_sum_accumulator.sv
// Bench for sum_accumulator: directed scenarios plus randomized traffic,
// checked against a frame-level arithmetic model (12-bit and 6-bit instances).
module tb_sum_accumulator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, clear, in_valid, out_ready;
  logic [4:0] in_data;

  logic        in_ready_a, out_valid_a, out_ovf_a;
  logic [11:0] out_sum_a, out_mean_a;
  logic        in_ready_b, out_valid_b, out_ovf_b;
  logic [5:0]  out_sum_b, out_mean_b;

  sum_accumulator #(.IN_W(5), .ACC_W(12), .FRAME_LEN(8)) dut_a (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready_a), .out_valid(out_valid_a), .out_ready(out_ready),
    .out_sum(out_sum_a), .out_mean(out_mean_a), .out_ovf(out_ovf_a));

  sum_accumulator #(.IN_W(5), .ACC_W(6), .FRAME_LEN(8)) dut_b (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready_b), .out_valid(out_valid_b), .out_ready(out_ready),
    .out_sum(out_sum_b), .out_mean(out_mean_b), .out_ovf(out_ovf_b));

  int checks = 0;
  int passes = 0;

  // Model: samples of the open frame, whether a result is pending, and the
  // exact (unbounded) total of the last completed frame.
  int unsigned frame_q[$];
  bit          m_hold = 1'b0;
  int unsigned m_total = 0;

  function automatic int unsigned exp_sum(input int unsigned w);
    return m_total % (32'd1 << w);
  endfunction

  function automatic bit exp_ovf(input int unsigned w);
    return m_total >= (32'd1 << w);
  endfunction

  task automatic step(input bit v, input int unsigned d, input bit r, input bit c, input bit rdy);
    int unsigned t;
    rst = r; clear = c; in_valid = v; in_data = 5'(d); out_ready = rdy;
    if (r) begin
      frame_q.delete(); m_hold = 1'b0; m_total = 0;
    end else if (c) begin
      frame_q.delete(); m_hold = 1'b0;
    end else if (m_hold) begin
      if (rdy) m_hold = 1'b0;
    end else if (v) begin
      frame_q.push_back(d);
      if (frame_q.size() == 8) begin
        t = 0;
        foreach (frame_q[i]) t += frame_q[i];
        m_total = t;
        m_hold  = 1'b1;
        frame_q.delete();
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    checks++; if (out_valid_a !== 1'b0) $display("FAIL rst_valid actual=%0b expected=0", out_valid_a); else passes++;
    checks++; if (out_sum_a !== 12'd0) $display("FAIL rst_sum actual=%0d expected=0", out_sum_a); else passes++;
    checks++; if (out_mean_a !== 12'd0 || out_ovf_a !== 1'b0) $display("FAIL rst_mean_ovf actual=%0d/%0b expected=0/0", out_mean_a, out_ovf_a); else passes++;
    step(0, 0, 0, 0, 0);
    checks++; if (in_ready_a !== 1'b1) $display("FAIL rst_in_ready actual=%0b expected=1", in_ready_a); else passes++;
  endtask

  task automatic test_defaults();
    for (int i = 1; i <= 8; i++) begin
      checks++; if (out_valid_a !== 1'b0) $display("FAIL def_early_valid sample=%0d actual=%0b expected=0", i, out_valid_a); else passes++;
      step(1, i, 0, 0, 0);
    end
    checks++; if (out_valid_a !== 1'b1) $display("FAIL def_valid actual=%0b expected=1", out_valid_a); else passes++;
    checks++; if (out_sum_a !== 12'd36) $display("FAIL def_sum actual=%0d expected=36", out_sum_a); else passes++;
    checks++; if (out_mean_a !== 12'd4) $display("FAIL def_mean actual=%0d expected=4", out_mean_a); else passes++;
    checks++; if (out_ovf_a !== 1'b0) $display("FAIL def_ovf actual=%0b expected=0", out_ovf_a); else passes++;
    checks++; if (in_ready_a !== 1'b0) $display("FAIL def_in_ready_hold actual=%0b expected=0", in_ready_a); else passes++;
    step(0, 0, 0, 0, 1);
    checks++; if (out_valid_a !== 1'b0 || in_ready_a !== 1'b1) $display("FAIL def_release actual=%0b/%0b expected=0/1", out_valid_a, in_ready_a); else passes++;
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 8; i++) step(1, 31, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      checks++; if (out_valid_a !== 1'b1 || in_ready_a !== 1'b0) $display("FAIL bp_hs cyc=%0d actual=%0b/%0b expected=1/0", k, out_valid_a, in_ready_a); else passes++;
      checks++; if (out_sum_a !== 12'd248 || out_mean_a !== 12'd31) $display("FAIL bp_data cyc=%0d actual=%0d/%0d expected=248/31", k, out_sum_a, out_mean_a); else passes++;
      step(1, 9, 0, 0, 0);
    end
    step(0, 0, 0, 0, 1);
    checks++; if (in_ready_a !== 1'b1 || out_valid_a !== 1'b0) $display("FAIL bp_release actual=%0b/%0b expected=1/0", in_ready_a, out_valid_a); else passes++;
    for (int i = 0; i < 8; i++) step(1, 1, 0, 0, 0);
    checks++; if (out_valid_a !== 1'b1 || out_sum_a !== 12'd8) $display("FAIL bp_next_sum actual=%0b/%0d expected=1/8", out_valid_a, out_sum_a); else passes++;
    step(0, 0, 0, 0, 1);
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 8; i++) step(1, 31, 0, 0, 0);
    checks++; if (out_sum_b !== 6'd56) $display("FAIL ovf_sum actual=%0d expected=56", out_sum_b); else passes++;
    checks++; if (out_mean_b !== 6'd7) $display("FAIL ovf_mean actual=%0d expected=7", out_mean_b); else passes++;
    checks++; if (out_ovf_b !== 1'b1) $display("FAIL ovf_flag actual=%0b expected=1", out_ovf_b); else passes++;
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 8; i++) step(1, 2, 0, 0, 0);
    checks++; if (out_sum_b !== 6'd16 || out_ovf_b !== 1'b0) $display("FAIL ovf_next actual=%0d/%0b expected=16/0", out_sum_b, out_ovf_b); else passes++;
    step(0, 0, 0, 0, 1);
  endtask

  task automatic test_clear();
    for (int i = 0; i < 3; i++) step(1, 10, 0, 0, 0);
    step(1, 10, 0, 1, 0);
    for (int i = 0; i < 8; i++) step(1, 3, 0, 0, 0);
    checks++; if (out_valid_a !== 1'b1 || out_sum_a !== 12'd24) $display("FAIL clr_sum actual=%0b/%0d expected=1/24", out_valid_a, out_sum_a); else passes++;
    step(1, 4, 0, 1, 0);
    checks++; if (out_valid_a !== 1'b0 || in_ready_a !== 1'b1) $display("FAIL clr_hold_drop actual=%0b/%0b expected=0/1", out_valid_a, in_ready_a); else passes++;
  endtask

  task automatic test_gapped_reset();
    for (int i = 0; i < 16; i++) step((i % 2) == 0, 5, 0, 0, 0);
    checks++; if (out_valid_a !== 1'b1 || out_sum_a !== 12'd40) $display("FAIL gap_sum actual=%0b/%0d expected=1/40", out_valid_a, out_sum_a); else passes++;
    step(0, 0, 1, 0, 0);
    checks++; if (out_valid_a !== 1'b0 || out_sum_a !== 12'd0 || in_ready_a !== 1'b1) $display("FAIL hold_rst actual=%0b/%0d/%0b expected=0/0/1", out_valid_a, out_sum_a, in_ready_a); else passes++;
    for (int i = 0; i < 8; i++) step(1, 1, 0, 0, 0);
    checks++; if (out_valid_a !== 1'b1 || out_sum_a !== 12'd8) $display("FAIL rst_fresh_sum actual=%0b/%0d expected=1/8", out_valid_a, out_sum_a); else passes++;
    step(0, 0, 0, 0, 1);
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 31), 0, $urandom_range(0, 49) == 0, $urandom_range(0, 2) == 0);
      checks++; if (out_valid_a !== m_hold || in_ready_a !== !m_hold) $display("FAIL rnd_hs cyc=%0d actual=%0b/%0b expected=%0b/%0b", k, out_valid_a, in_ready_a, m_hold, !m_hold); else passes++;
      if (m_hold) begin
        checks++; if (out_sum_a !== exp_sum(12) || out_mean_a !== (exp_sum(12) >> 3)) $display("FAIL rnd_a cyc=%0d actual=%0d/%0d expected=%0d/%0d", k, out_sum_a, out_mean_a, exp_sum(12), exp_sum(12) >> 3); else passes++;
        checks++; if (out_sum_b !== exp_sum(6) || out_mean_b !== (exp_sum(6) >> 3) || out_ovf_b !== exp_ovf(6)) $display("FAIL rnd_b cyc=%0d actual=%0d/%0d/%0b expected=%0d/%0d/%0b", k, out_sum_b, out_mean_b, out_ovf_b, exp_sum(6), exp_sum(6) >> 3, exp_ovf(6)); else passes++;
      end
    end
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    test_reset();
    test_defaults();
    test_backpressure();
    test_overflow();
    test_clear();
    test_gapped_reset();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/sum_accumulator.md
Name: sum_accumulator

Overview:
- Sits directly downstream of the registered adder. Consumes its sum outputs through a valid/ready handshake and accumulates a fixed-length frame of FRAME_LEN samples.
- At the end of each frame it presents the frame total, the truncated mean and an overflow flag on an output valid/ready handshake.
- Provides frame-level reduction of adder results for the checker and scoreboard path.

Parameters:
- IN_W, 5, width of the incoming adder sum (4-bit operands plus carry).
- ACC_W, 12, accumulator and frame-total width.
- FRAME_LEN, 8, samples per frame; must be a power of two and at least 2.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- clear  input  1  synchronous frame abort.
- in_valid  input  1  upstream sample valid.
- in_data  input  IN_W  upstream sample (adder sum).
- in_ready  output  1  block can accept a sample.
- out_valid  output  1  frame result valid.
- out_ready  input  1  downstream accepts result.
- out_sum  output  ACC_W  frame total, modulo 2^ACC_W.
- out_mean  output  ACC_W  out_sum >> log2(FRAME_LEN).
- out_ovf  output  1  a carry out of ACC_W occurred during the frame.

Behaviour:
- Reset: one clock, synchronous, active-high, as decided. While rst is high at a rising edge:
  - state goes to ACCUM; accumulator, sample count and ovf are cleared.
  - out_valid=0, out_sum=0, out_mean=0, out_ovf=0.
  - in_ready is 1 from the first cycle after reset deasserts.
- Priority: rst > clear > handshakes.
- State ACCUM:
  - in_ready=1 and out_valid=0.
  - A sample is accepted when in_valid && in_ready at the edge. Accumulator becomes acc + zero-extended in_data (modulo 2^ACC_W), and count increments.
  - Carry out of bit ACC_W-1 sets the sticky ovf.
  - in_valid low means no change; gaps are allowed.
- ACCUM to HOLD: on acceptance of the FRAME_LEN-th sample.
  - The total including that sample is registered into out_sum, out_mean and out_ovf.
  - out_valid=1 in the following cycle, so latency is 1 cycle from the last accepted sample.
- State HOLD:
  - in_ready=0; in_valid is ignored.
  - out_sum, out_mean and out_ovf stay stable while out_valid=1 && out_ready=0.
- HOLD to ACCUM: on out_valid && out_ready.
  - The next cycle has out_valid=0 and in_ready=1.
  - Accumulator, count and ovf are zero, so no sample from the old frame leaks in.
  - out_sum, out_mean and out_ovf keep their last values but are don't-care while out_valid=0.
- in_ready is combinational from state only, with no dependence on out_ready; there is no same-cycle pass-through.
- clear:
  - In either state, the next cycle is ACCUM with acc=0, count=0, ovf=0 and out_valid=0.
  - A pending result in HOLD is discarded.
  - A sample presented in the same cycle as clear is dropped.
- Count: width clog2(FRAME_LEN)+1. It wraps to 0 on frame completion; it never exceeds FRAME_LEN.
- Width rule: in_data is zero-extended to ACC_W. out_mean is a logical right shift with no rounding.
- rst asserted mid-frame or in HOLD discards all state; no result is emitted.

Decomposition:
- Package sum_accumulator_pkg holds:
  - state enum typedef (ACCUM, HOLD), 1-bit logic encoding.
  - localparam function for log2 of FRAME_LEN.
- Single module, no sub-module. The datapath (adder plus carry) and the 2-state FSM are small enough to keep flat.

Test Plan:
- Defaults. After rst, send 1,2,3,4,5,6,7,8 back-to-back → out_valid one cycle after the 8th, out_sum=36, out_mean=4, out_ovf=0, in_ready=0 during HOLD.
- Backpressure. Frame of eight 31s with out_ready=0 for 5 cycles → out_sum=248, out_mean=31, held stable for all 5 cycles. in_ready stays 0 and in_valid is ignored. After out_ready=1, in_ready=1 on the next cycle and the next frame of eight 1s gives out_sum=8.
- Overflow (ACC_W=6). Eight samples of 31 → out_sum=56 (248 mod 64), out_mean=7, out_ovf=1. The next frame of eight 2s → out_sum=16, out_ovf=0 (flag does not carry across frames).
- Clear mid-frame. Accept 10,10,10, assert clear with in_valid=1, in_data=10 → that sample is dropped. Then eight 3s → out_sum=24.
- Gapped input and reset. Samples 5 with in_valid toggling every other cycle → out_sum=40 after 8 accepts. Assert rst while in HOLD with out_ready=0 → next cycle out_valid=0, out_sum=0, in_ready=1, and a fresh frame of eight 1s → out_sum=8.
